spw_tx_queue: RTL and testbench
===============================

Name: spw_tx_queue

Overview:
- Transmit-side character queue for the SpaceWire link. Mirrors the receive queue on the opposite path.
- The host writes 9-bit characters {lchar, char} into an 8-deep buffer over a strobe/ack handshake.
- The drain side emits one N-char or L-char (EOP/EEP) at a time toward the link transmitter.
- Emission is gated by transmitter busy and by the flow-control credit count, which is replenished by received FCTs.

Parameters:
- DEPTH_LOG2, 3: log2 of queue depth (8 slots).
- CREDIT_PER_FCT, 8: credits added per fct_i pulse.
- MAX_CREDIT, 56: credit ceiling; must fit in credit_o width (6 bits).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dat_i  in  9  host character; bit8 = lchar flag, bits7:0 = data; for L-chars bits1:0 01=EOP, 10=EEP.
- stb_i  in  1  host write strobe; held until ack_o is seen.
- ack_o  out  1  registered one-cycle write acknowledge.
- full_o  out  1  all slots occupied.
- empty_o  out  1  no slots occupied.
- tx_busy_i  in  1  transmitter cannot accept a character this cycle.
- fct_i  in  1  one-cycle pulse: FCT received from far end.
- nchar_o  out  1  one-cycle pulse: char_o is an N-char.
- lchar_o  out  1  one-cycle pulse: char_o is an L-char (EOP/EEP in bits1:0).
- char_o  out  8  character data, valid while nchar_o or lchar_o is high.
- credit_o  out  6  current credit count.
- credit_error_o  out  1  sticky credit overflow flag.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - rp=0, wp=0, occupancy=0.
  - ack_o=0, nchar_o=0, lchar_o=0, char_o=0.
  - credit=0, credit_error_o=0, holdoff=0.
  - empty_o=1, full_o=0.
  - Reset mid-operation discards all queued characters and credit. No pulse is emitted in the reset cycle.
- Host write:
  - At an edge with stb_i=1, ack_o=0, full_o=0: latch dat_i, set ack_o=1 next cycle.
  - ack_o always returns to 0 on the following edge, so at most one write per 2 cycles.
  - If full_o=1, no ack is given; the host keeps stb_i high until space frees.
  - An L-char whose bits1:0 are 00 or 11 is acked but discarded (not stored, no wp advance).
- Drain:
  - Emission condition: occupied=1, tx_busy_i=0, credit!=0, holdoff=0.
  - On emission:
    - Pulse nchar_o or lchar_o for one cycle with char_o = stored byte.
    - Advance rp and clear the slot.
    - Decrement credit (EOP/EEP consume credit like N-chars).
    - Set holdoff=1 for exactly one cycle, so at most one emission per 2 cycles and the transmitter has a cycle to raise tx_busy_i.
  - Emission latency from write edge to earliest pulse: 1 cycle, given credit>0 and not busy.
- Simultaneous write and pop:
  - Both occur; occupancy is unchanged.
  - When full, a pop in cycle N allows an ack in cycle N+1 or later (full_o is evaluated from registered state).
- Pointers are 3 bits and wrap modulo 8. full_o and empty_o are derived from occupancy, not from pointer equality.
- Credit:
  - next = credit - emit + (fct_i ? 8 : 0).
  - If next > 56: credit holds credit - emit (FCT ignored) and credit_error_o is set, sticky until reset.
  - When credit=0, the queue holds regardless of tx_busy_i.

Optional Feature:
- SPW_TX_FLUSH_EN defined:
  - Adds input flush_i (1 bit).
  - When flush_i=1 at an edge: rp<=wp, all occupancy cleared, no emission that cycle.
  - A host write in the same cycle is acked but discarded.
  - Credit is unaffected.
- Undefined: no flush_i port; the queue is emptied only by drain or reset.

Decomposition:
- Package spw_pkg:
  - Constants SPW_EOP=2'b01, SPW_EEP=2'b10, CREDIT_PER_FCT=8, MAX_CREDIT=56.
  - Typedef spw_char_t: 9-bit struct {lchar, data[7:0]}.
- Sub-module spw_credit_counter:
  - Holds the credit register, the overflow check and credit_error_o.
  - Inputs: fct_i, consume.
  - Outputs: credit, has_credit, error.
- Queue storage, pointers and holdoff remain in spw_tx_queue.

Test Plan:
- After reset, write N-chars 0x11, 0x22 with credit 0 -> both acked, empty_o=0, no nchar_o pulses.
- Pulse fct_i once -> credit_o=8; nchar_o pulses with 0x11 then 0x22, 2 cycles apart; credit_o=6; empty_o=1.
- Write 9 chars with credit 0 -> 8 acked, full_o=1; ninth stb_i held without ack until a pop after an fct_i pulse, then acked.
- Write L-char 0x101 (EOP), 0x102 (EEP), 0x100, 0x103 -> only EOP and EEP are emitted as lchar_o with char_o[1:0]=01 and 10; the other two are acked and dropped.
- Seven fct_i pulses (credit=56), then an eighth with no emission -> credit_o stays 56, credit_error_o=1 until reset. Repeat the eighth pulse in an emission cycle -> credit=55, error set.
- Hold tx_busy_i=1 with data and credit -> no pulses. Release -> a pulse in the next cycle. Assert reset mid-stream -> empty_o=1, credit_o=0, no further pulses.

Source files
------------

// File: rtl/spw_pkg.sv
// ============================================================================
// Module  : spw_pkg
// Brief   : Shared SpaceWire character types and link constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spw_pkg;

    localparam logic [1:0] SPW_EOP        = 2'b01;
    localparam logic [1:0] SPW_EEP        = 2'b10;
    localparam int         CREDIT_PER_FCT = 8;
    localparam int         MAX_CREDIT     = 56;
    localparam int         CREDIT_W       = 6;

    typedef struct packed {
        logic       lchar;
        logic [7:0] data;
    } spw_char_t;

    // Only EOP and EEP are legal L-chars on this path; other codes are dropped.
    function automatic logic spw_is_storable(input spw_char_t c);
        return !c.lchar || (c.data[1:0] == SPW_EOP) || (c.data[1:0] == SPW_EEP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spw_credit_counter.sv
// ============================================================================
// Module  : spw_credit_counter
// Brief   : Flow-control credit register with FCT overflow detection.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spw_credit_counter
    import spw_pkg::*;
#(
    parameter int CREDIT_INC = CREDIT_PER_FCT,
    parameter int CREDIT_MAX = MAX_CREDIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fct_i,
    input  logic                consume_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                has_credit_o,
    output logic                error_o
);

    localparam logic [CREDIT_W:0] c_INC = (CREDIT_W + 1)'(CREDIT_INC);
    localparam logic [CREDIT_W:0] c_MAX = (CREDIT_W + 1)'(CREDIT_MAX);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                error_q, error_d;
    logic [CREDIT_W:0]   w_after_use;
    logic [CREDIT_W:0]   w_with_fct;
    logic                w_use;

    assign w_use       = consume_i && (credit_q != '0);
    assign w_after_use = {1'b0, credit_q} - {{CREDIT_W{1'b0}}, w_use};
    assign w_with_fct  = w_after_use + c_INC;

    always_comb begin
        credit_d = w_after_use[CREDIT_W-1:0];
        error_d  = error_q;
        if (fct_i) begin
            // An FCT that would exceed the ceiling is dropped, not clipped.
            if (w_with_fct > c_MAX) begin
                error_d = 1'b1;
            end else begin
                credit_d = w_with_fct[CREDIT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
            error_q  <= 1'b0;
        end else begin
            credit_q <= credit_d;
            error_q  <= error_d;
        end
    end

    assign credit_o     = credit_q;
    assign has_credit_o = (credit_q != '0);
    assign error_o      = error_q;

endmodule

`default_nettype wire

// File: rtl/spw_tx_queue.sv
// ============================================================================
// Module  : spw_tx_queue
// Brief   : SpaceWire transmit character queue with credit-gated drain.
//           Optional flush input enabled by defining SPW_TX_FLUSH_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spw_tx_queue
    import spw_pkg::*;
#(
    parameter int DEPTH_LOG2     = 3,
    parameter int CREDIT_PER_FCT = spw_pkg::CREDIT_PER_FCT,
    parameter int MAX_CREDIT     = spw_pkg::MAX_CREDIT
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SPW_TX_FLUSH_EN
    input  logic                flush_i,
`endif
    input  logic [8:0]          dat_i,
    input  logic                stb_i,
    output logic                ack_o,
    output logic                full_o,
    output logic                empty_o,
    input  logic                tx_busy_i,
    input  logic                fct_i,
    output logic                nchar_o,
    output logic                lchar_o,
    output logic [7:0]          char_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                credit_error_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    spw_char_t             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ack_q, holdoff_q;
    logic                  nchar_q, nchar_d, lchar_q, lchar_d;
    logic [7:0]            char_q, char_d;

    logic                  w_flush;
    logic                  w_full, w_empty;
    logic                  w_accept, w_store, w_emit;
    logic                  w_has_credit;
    spw_char_t             w_in_char, w_head;

`ifdef SPW_TX_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign w_in_char = spw_char_t'(dat_i);
    assign w_head    = mem_q[rp_q];
    assign w_full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign w_empty   = (count_q == '0);

    // Any accepted strobe is acked; only legal characters consume a slot.
    assign w_accept  = stb_i && !ack_q && !w_full;
    assign w_store   = w_accept && !w_flush && spw_is_storable(w_in_char);
    assign w_emit    = !w_empty && !tx_busy_i && w_has_credit && !holdoff_q && !w_flush;

    spw_credit_counter #(
        .CREDIT_INC (CREDIT_PER_FCT),
        .CREDIT_MAX (MAX_CREDIT)
    ) u_credit (
        .clk          (clk),
        .reset        (reset),
        .fct_i        (fct_i),
        .consume_i    (w_emit),
        .credit_o     (credit_o),
        .has_credit_o (w_has_credit),
        .error_o      (credit_error_o)
    );

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        nchar_d = w_emit && !w_head.lchar;
        lchar_d = w_emit && w_head.lchar;
        char_d  = w_emit ? w_head.data : char_q;
        if (w_flush) begin
            rp_d    = wp_q;
            count_d = '0;
        end else begin
            if (w_store) begin
                wp_d = wp_q + 1'b1;
            end
            if (w_emit) begin
                rp_d = rp_q + 1'b1;
            end
            case ({w_store, w_emit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp_q      <= '0;
            wp_q      <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            holdoff_q <= 1'b0;
            nchar_q   <= 1'b0;
            lchar_q   <= 1'b0;
            char_q    <= '0;
        end else begin
            rp_q      <= rp_d;
            wp_q      <= wp_d;
            count_q   <= count_d;
            ack_q     <= w_accept;
            holdoff_q <= w_emit;
            nchar_q   <= nchar_d;
            lchar_q   <= lchar_d;
            char_q    <= char_d;
        end
    end

    // Store and drain never target the same slot: that needs count 0 or DEPTH.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset || w_flush) begin
                mem_q[gi] <= '0;
            end else if (w_store && (wp_q == DEPTH_LOG2'(gi))) begin
                mem_q[gi] <= w_in_char;
            end else if (w_emit && (rp_q == DEPTH_LOG2'(gi))) begin
                mem_q[gi] <= '0;
            end
        end
    end

    assign ack_o   = ack_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign nchar_o = nchar_q;
    assign lchar_o = lchar_q;
    assign char_o  = char_q;

endmodule

`default_nettype wire

// File: tb/tb_spw_tx_queue.sv
// ============================================================================
// Module  : tb_spw_tx_queue
// Brief   : Directed scoreboard bench for spw_tx_queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spw_tx_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] dat_i = '0;
    logic       stb_i = 1'b0;
    logic       tx_busy_i = 1'b0;
    logic       fct_i = 1'b0;
    logic       ack_o, full_o, empty_o, nchar_o, lchar_o, credit_error_o;
    logic [7:0] char_o;
    logic [5:0] credit_o;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         prev_cyc = 0;
    logic [8:0] sb [$];

    spw_tx_queue dut (
        .clk            (clk),
        .reset          (reset),
`ifdef SPW_TX_FLUSH_EN
        .flush_i        (1'b0),
`endif
        .dat_i          (dat_i),
        .stb_i          (stb_i),
        .ack_o          (ack_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .tx_busy_i      (tx_busy_i),
        .fct_i          (fct_i),
        .nchar_o        (nchar_o),
        .lchar_o        (lchar_o),
        .char_o         (char_o),
        .credit_o       (credit_o),
        .credit_error_o (credit_error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [8:0] d, input bit keep);
        bit got;
        got   = 1'b0;
        stb_i = 1'b1;
        dat_i = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
        stb_i = 1'b0;
        chk("write_ack", {31'd0, got}, 32'd1);
        if (keep && got) sb.push_back(d);
    endtask

    task automatic fct_pulse();
        fct_i = 1'b1;
        tick();
        fct_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        sb.delete();
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        logic [8:0] exp;
        #1;
        if (nchar_o || lchar_o) begin
            pulses++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            chk("pulse_exclusive", {31'd0, nchar_o && lchar_o}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {23'd0, lchar_o, char_o}, 32'h1ff);
            end else begin
                exp = sb.pop_front();
                chk("char_out", {23'd0, lchar_o, char_o}, {23'd0, exp});
            end
        end
    end

    initial begin
        int  p0;
        bit  ack_seen;
        bit  got;

        ticks(2);
        reset = 1'b0;
        chk("rst_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        chk("rst_credit", {26'd0, credit_o}, 32'd0);
        chk("rst_err", {31'd0, credit_error_o}, 32'd0);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_pulse", {30'd0, nchar_o, lchar_o}, 32'd0);
        chk("rst_char", {24'd0, char_o}, 32'd0);

        // Two N-chars held back by zero credit.
        wr(9'h011, 1'b1);
        wr(9'h022, 1'b1);
        ticks(3);
        chk("hold_not_empty", {31'd0, empty_o}, 32'd0);
        chk("hold_no_pulse", pulses, 0);

        fct_pulse();
        chk("credit_after_fct", {26'd0, credit_o}, 32'd8);
        ticks(6);
        chk("drain_pulses", pulses, 2);
        chk("drain_gap", last_cyc - prev_cyc, 2);
        chk("drain_credit", {26'd0, credit_o}, 32'd6);
        chk("drain_empty", {31'd0, empty_o}, 32'd1);

        // Spend the remaining credit, then fill the queue.
        for (int i = 0; i < 6; i++) wr(9'h030 + 9'(i), 1'b1);
        ticks(6);
        chk("spent_credit", {26'd0, credit_o}, 32'd0);
        chk("spent_pulses", pulses, 8);
        for (int i = 0; i < 8; i++) wr(9'h040 + 9'(i), 1'b1);
        tick();
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_no_pulse", pulses, 8);

        stb_i = 1'b1;
        dat_i = 9'h048;
        ack_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack_o) ack_seen = 1'b1;
        end
        chk("no_ack_when_full", {31'd0, ack_seen}, 32'd0);
        fct_pulse();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_o) begin
                got = 1'b1;
                break;
            end
        end
        stb_i = 1'b0;
        chk("ack_after_pop", {31'd0, got}, 32'd1);
        if (got) sb.push_back(9'h048);
        ticks(20);
        chk("ninth_pending", {31'd0, empty_o}, 32'd0);
        chk("ninth_credit0", {26'd0, credit_o}, 32'd0);
        fct_pulse();
        ticks(4);
        chk("ninth_drained", {31'd0, empty_o}, 32'd1);
        chk("ninth_credit", {26'd0, credit_o}, 32'd7);
        chk("fill_pulses", pulses, 17);

        // L-chars: only EOP and EEP survive.
        p0 = pulses;
        wr(9'h101, 1'b1);
        wr(9'h102, 1'b1);
        wr(9'h100, 1'b0);
        wr(9'h103, 1'b0);
        ticks(6);
        chk("lchar_pulses", pulses - p0, 2);
        chk("lchar_sb_empty", sb.size(), 0);
        chk("lchar_credit", {26'd0, credit_o}, 32'd5);
        chk("lchar_empty", {31'd0, empty_o}, 32'd1);

        // Credit ceiling and sticky overflow.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            fct_pulse();
            tick();
        end
        chk("credit_max", {26'd0, credit_o}, 32'd56);
        chk("credit_no_err", {31'd0, credit_error_o}, 32'd0);
        fct_pulse();
        chk("overflow_credit", {26'd0, credit_o}, 32'd56);
        chk("overflow_err", {31'd0, credit_error_o}, 32'd1);
        p0 = pulses;
        wr(9'h0aa, 1'b1);
        fct_pulse();
        chk("overflow_emit_credit", {26'd0, credit_o}, 32'd55);
        chk("overflow_emit_pulse", pulses - p0, 1);
        ticks(3);
        chk("err_sticky", {31'd0, credit_error_o}, 32'd1);

        // Transmitter busy, then reset mid-stream.
        tx_busy_i = 1'b1;
        p0 = pulses;
        wr(9'h0b1, 1'b1);
        wr(9'h0b2, 1'b1);
        ticks(4);
        chk("busy_no_pulse", pulses - p0, 0);
        tx_busy_i = 1'b0;
        tick();
        chk("release_pulse", {31'd0, nchar_o}, 32'd1);
        chk("release_char", {24'd0, char_o}, 32'h0b1);
        reset = 1'b1;
        tick();
        chk("midrst_no_pulse", {30'd0, nchar_o, lchar_o}, 32'd0);
        reset = 1'b0;
        sb.delete();
        p0 = pulses;
        chk("midrst_empty", {31'd0, empty_o}, 32'd1);
        chk("midrst_credit", {26'd0, credit_o}, 32'd0);
        chk("midrst_err", {31'd0, credit_error_o}, 32'd0);
        ticks(5);
        chk("midrst_quiet", pulses - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
